// File: rtl/vgm_wb_master_engine_if.sv
// Command/response stream plus Wishbone B4 classic master signal bundle.
// The master modport faces the engine and the slave modport faces the requester/bus side.
interface vgm_wb_master_engine_if #(
  parameter int unsigned ADR_W = 32,
  parameter int unsigned DAT_W = 32
);
  localparam int unsigned SEL_W = DAT_W / 8;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [ADR_W-1:0] cmd_adr;
  logic [DAT_W-1:0] cmd_dat;
  logic [SEL_W-1:0] cmd_sel;
  logic             cmd_lock;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DAT_W-1:0] rsp_dat;
  logic [1:0]       rsp_status;
  logic [3:0]       rsp_retries;
  logic             CYC_O;
  logic             STB_O;
  logic             WE_O;
  logic [ADR_W-1:0] ADR_O;
  logic [DAT_W-1:0] DAT_O;
  logic [SEL_W-1:0] SEL_O;
  logic             ACK_I;
  logic             ERR_I;
  logic             RTY_I;
  logic [DAT_W-1:0] DAT_I;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, cmd_lock, rsp_ready,
           ACK_I, ERR_I, RTY_I, DAT_I,
    output cmd_ready, rsp_valid, rsp_dat, rsp_status, rsp_retries,
           CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, cmd_lock, rsp_ready,
           ACK_I, ERR_I, RTY_I, DAT_I,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_status, rsp_retries,
           CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O
  );
endinterface

// File: rtl/vgm_wb_master_engine.sv
// Wishbone B4 classic master: one command in, one bus cycle (with retries/timeout) out,
// one response back. All outputs registered; locked cycles keep CYC_O across commands.
module vgm_wb_master_engine #(
  parameter int unsigned ADR_W     = 32,
  parameter int unsigned DAT_W     = 32,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned TMO_W     = 8
) (
  input  logic                        CLK_I,
  input  logic                        RST_I,
  vgm_wb_master_engine_if.master      bus
);
  localparam int unsigned SEL_W = DAT_W / 8;
  localparam int unsigned RC_W  = (MAX_RETRY > 15) ? $clog2(MAX_RETRY + 1) : 4;
  localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_RETRY);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit               TMO_EN   = (TIMEOUT != 0);

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_ERR  = 2'd1;
  localparam logic [1:0] ST_RTYX = 2'd2;
  localparam logic [1:0] ST_TMO  = 2'd3;

  typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;

  state_t           state_q, state_d;
  logic             cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, lock_q, lock_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic [3:0]       rsp_retries_q, rsp_retries_d;
  logic [RC_W-1:0]  rty_q, rty_d;
  logic [TMO_W-1:0] tmr_q, tmr_d;
  logic [3:0]       rty_sat;

  assign rty_sat = (rty_q > RC_W'(15)) ? 4'hF : 4'(rty_q);

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    stb_d         = stb_q;
    we_d          = we_q;
    lock_d        = lock_q;
    adr_d         = adr_q;
    dat_d         = dat_q;
    sel_d         = sel_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_dat_d     = rsp_dat_q;
    rsp_status_d  = rsp_status_q;
    rsp_retries_d = rsp_retries_q;
    rty_d         = rty_q;
    tmr_d         = tmr_q;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d     = BUS;
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          we_d        = bus.cmd_we;
          adr_d       = bus.cmd_adr;
          dat_d       = bus.cmd_dat;
          sel_d       = bus.cmd_sel;
          lock_d      = bus.cmd_lock;
          rty_d       = '0;
          tmr_d       = '0;
        end
      end
      BUS: begin
        rsp_retries_d = rty_sat;
        rsp_dat_d     = '0;
        if (bus.ACK_I) begin
          state_d      = RESP;
          stb_d        = 1'b0;
          cyc_d        = lock_q;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_OK;
          rsp_dat_d    = we_q ? '0 : bus.DAT_I;
        end else if (bus.ERR_I) begin
          state_d      = RESP;
          stb_d        = 1'b0;
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_ERR;
        end else if (bus.RTY_I) begin
          if (rty_q < RC_MAX) begin
            state_d = GAP;
            stb_d   = 1'b0;
            rty_d   = rty_q + RC_W'(1);
            tmr_d   = '0;
          end else begin
            state_d      = RESP;
            stb_d        = 1'b0;
            cyc_d        = 1'b0;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_RTYX;
          end
        end else if (TMO_EN && (tmr_q == TMO_LAST)) begin
          state_d      = RESP;
          stb_d        = 1'b0;
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TMO;
        end else begin
          tmr_d = tmr_q + TMO_W'(1);
        end
      end
      GAP: begin
        state_d = BUS;
        stb_d   = 1'b1;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q       <= IDLE;
      cyc_q         <= 1'b0;
      stb_q         <= 1'b0;
      we_q          <= 1'b0;
      lock_q        <= 1'b0;
      adr_q         <= '0;
      dat_q         <= '0;
      sel_q         <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_dat_q     <= '0;
      rsp_status_q  <= '0;
      rsp_retries_q <= '0;
      rty_q         <= '0;
      tmr_q         <= '0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      stb_q         <= stb_d;
      we_q          <= we_d;
      lock_q        <= lock_d;
      adr_q         <= adr_d;
      dat_q         <= dat_d;
      sel_q         <= sel_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_dat_q     <= rsp_dat_d;
      rsp_status_q  <= rsp_status_d;
      rsp_retries_q <= rsp_retries_d;
      rty_q         <= rty_d;
      tmr_q         <= tmr_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_dat     = rsp_dat_q;
  assign bus.rsp_status  = rsp_status_q;
  assign bus.rsp_retries = rsp_retries_q;
  assign bus.CYC_O       = cyc_q;
  assign bus.STB_O       = stb_q;
  assign bus.WE_O        = we_q;
  assign bus.ADR_O       = adr_q;
  assign bus.DAT_O       = dat_q;
  assign bus.SEL_O       = sel_q;
endmodule

// File: doc/vgm_wb_master_engine.md
Name: vgm_wb_master_engine

Overview:
- Synthesizable Wishbone B4 classic master engine that turns a simple command/response stream into Wishbone bus cycles.
- Generalised over the fixed 32-bit master signal set:
  - parametrised address and data widths
  - byte selects (SEL_O)
  - ERR_I/RTY_I termination
  - bounded automatic retry
  - cycle timeout
  - locked (back-to-back) cycles that hold CYC_O across commands
- Sits between testbench/firmware-model sequencers or on-chip requesters and any Wishbone slave.

Parameters:
ADR_W, 32, address width
DAT_W, 32, data width; multiple of 8
SEL_W, DAT_W/8, byte-select width (derived, not overridable)
MAX_RETRY, 3, RTY_I terminations re-issued before giving up; 0 = no retries
TIMEOUT, 16, consecutive unterminated STB_O cycles before abort; 0 = disabled
TMO_W, 8, width of timeout counter; TIMEOUT < 2**TMO_W

Ports:
CLK_I  in  1  clock, all logic on rising edge
RST_I  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  engine accepts command
cmd_we  in  1  1 = write, 0 = read
cmd_adr  in  ADR_W  address
cmd_dat  in  DAT_W  write data
cmd_sel  in  SEL_W  byte selects
cmd_lock  in  1  keep CYC_O asserted after this transfer completes OK
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_dat  out  DAT_W  read data (0 for writes and failures)
rsp_status  out  2  0 OK, 1 ERR, 2 RETRY_EXHAUSTED, 3 TIMEOUT
rsp_retries  out  4  number of retries performed (saturating at 15)
CYC_O, STB_O, WE_O  out  1  Wishbone cycle/strobe/write enable
ADR_O  out  ADR_W  Wishbone address
DAT_O  out  DAT_W  Wishbone write data
SEL_O  out  SEL_W  Wishbone byte selects
ACK_I, ERR_I, RTY_I  in  1  Wishbone terminations
DAT_I  in  DAT_W  Wishbone read data

Behaviour:
- Reset (RST_I low, asynchronous):
  - State forced to IDLE immediately, aborting any bus cycle mid-transfer.
  - All outputs 0 (cmd_ready rises the first clock after release); counters and lock flag cleared.
- States: IDLE, BUS, GAP, RESP. All outputs are registered.
- IDLE:
  - cmd_ready = 1. On cmd_valid & cmd_ready, latch we/adr/dat/sel/lock and go to BUS.
  - Next cycle: CYC_O = STB_O = 1; ADR_O/DAT_O/SEL_O/WE_O driven from the latched values.
  - retry count and timer cleared.
- BUS (STB_O = 1), terminations sampled each edge. Priority when several are high: ACK_I > ERR_I > RTY_I.
  - ACK_I: STB_O drops; read → rsp_dat = DAT_I; status 0; go to RESP.
  - ERR_I: STB_O and CYC_O drop; status 1; go to RESP.
  - RTY_I, retries < MAX_RETRY: STB_O drops for exactly one cycle (GAP, CYC_O held); retries++; timer cleared; return to BUS.
  - RTY_I, retries == MAX_RETRY: CYC_O and STB_O drop; status 2; go to RESP.
  - No termination: timer++. When the timer reaches TIMEOUT (TIMEOUT ≠ 0): CYC_O and STB_O drop; status 3; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_* held stable until rsp_ready; then go to IDLE and rsp_valid = 0.
  - cmd_ready stays 0 in RESP.
- Latency: command accepted at edge t → STB_O high after edge t; zero-wait ACK at edge t+1 → rsp_valid high after edge t+1.
- Lock:
  - On an OK termination with lock set, CYC_O remains 1 through RESP and IDLE until the next command.
  - The next command's STB_O is issued inside the same CYC.
  - With lock clear, or on any failure status, CYC_O drops at termination.
- Outputs other than CYC_O/STB_O keep their last values while idle (don't-care to slaves).
- rsp_dat is forced to 0 for writes and for non-OK status.

Test Plan:
- Read at 0x0000_0100, SEL = 0xF, slave ACKs with DAT_I = 0xDEAD_BEEF after 2 wait states → STB_O high 3 cycles; rsp_dat = 0xDEAD_BEEF, status 0, retries 0; CYC_O low after ACK.
- Write 0xA5A5_0000 to 0x40, SEL = 0x3, zero-wait ACK → WE_O = 1, SEL_O = 0x3 during STB; rsp_valid 2 cycles after accept; rsp_dat = 0.
- Slave asserts RTY_I 2 times then ACK (MAX_RETRY = 3) → two one-cycle STB gaps with CYC held; status 0, retries 2. RTY_I 4 times → status 2, retries 3.
- Slave silent, TIMEOUT = 16 → CYC_O/STB_O drop after 16 STB cycles; status 3. ACK_I and ERR_I high simultaneously → status 0.
- Two commands, first with cmd_lock = 1, both ACKed → CYC_O continuously high from first STB through second ACK; rsp_ready held low 5 cycles → response stable, cmd_ready 0.
- RST_I pulled low mid-BUS → CYC_O/STB_O/rsp_valid 0 immediately, before the next edge; after release, a new read completes normally.
